// File: rtl/bldc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bldc_pkg
//  Description : Shared encodings and the six-step commutation table for the
//                BLDC commutator and its dead-time legs.
//                Leg drive codes  : OFF / HIGH / LOW (2 bits)
//                Leg FSM states   : IDLE / HIGH / LOW / DEAD (2 bits)
//                Helper functions : hall_invalid(), comm_table()
//  Revision    : 1.0 - initial release
// ============================================================================
package bldc_pkg;

  // Requested drive for one half-bridge leg
  localparam logic [1:0] DRV_OFF  = 2'b00;
  localparam logic [1:0] DRV_HIGH = 2'b01;
  localparam logic [1:0] DRV_LOW  = 2'b10;

  // Dead-time leg FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_HIGH = 2'b01;
  localparam logic [1:0] ST_LOW  = 2'b10;
  localparam logic [1:0] ST_DEAD = 2'b11;

  // Hall codes that can never occur with healthy sensors
  localparam logic [2:0] HALL_BAD_LO = 3'b000;
  localparam logic [2:0] HALL_BAD_HI = 3'b111;

  function automatic logic hall_invalid(input logic [2:0] hs);
    return (hs == HALL_BAD_LO) || (hs == HALL_BAD_HI);
  endfunction

  // Returns {drv_C, drv_B, drv_A}: DRV_HIGH marks the leg that carries PWM,
  // DRV_LOW the leg that is held low, DRV_OFF the floating leg.
  // dir=1 swaps the high/low roles of the same row.
  function automatic logic [5:0] comm_table(input logic [2:0] hs, input logic dir);
    logic [2:0] hi;
    logic [2:0] lo;
    logic [2:0] tmp;
    logic [5:0] res;
    hi = 3'b000;
    lo = 3'b000;
    case (hs)
      3'b101:  begin hi = 3'b001; lo = 3'b010; end
      3'b100:  begin hi = 3'b001; lo = 3'b100; end
      3'b110:  begin hi = 3'b010; lo = 3'b100; end
      3'b010:  begin hi = 3'b010; lo = 3'b001; end
      3'b011:  begin hi = 3'b100; lo = 3'b001; end
      3'b001:  begin hi = 3'b100; lo = 3'b010; end
      default: begin hi = 3'b000; lo = 3'b000; end
    endcase
    if (dir) begin
      tmp = hi;
      hi  = lo;
      lo  = tmp;
    end
    res = 6'b0;
    for (int i = 0; i < 3; i++) begin
      res[2*i +: 2] = hi[i] ? DRV_HIGH : (lo[i] ? DRV_LOW : DRV_OFF);
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bldc_commutator_if.sv
`default_nettype none
// ============================================================================
//  Module      : bldc_commutator_if
//  Description : Control/gate bundle of the BLDC commutator.
//                master : drives en, pwm_in, dir, phase_state; observes gates
//                slave  : the commutator itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface bldc_commutator_if;
  logic       en;
  logic       pwm_in;
  logic       dir;
  logic [2:0] phase_state;
  logic [2:0] gate_h;
  logic [2:0] gate_l;
  logic       fault;
  logic       commutate;

  modport master (
    output en, pwm_in, dir, phase_state,
    input  gate_h, gate_l, fault, commutate
  );

  modport slave (
    input  en, pwm_in, dir, phase_state,
    output gate_h, gate_l, fault, commutate
  );
endinterface
`default_nettype wire

// File: rtl/bldc_deadtime_leg.sv
`default_nettype none
// ============================================================================
//  Module      : bldc_deadtime_leg
//  Description : One half-bridge leg with dead-time insertion.
//  Ports       : clk   - system clock
//                rst   - asynchronous active-low reset
//                drive - requested drive (DRV_OFF / DRV_HIGH / DRV_LOW)
//                gh/gl - registered high/low side gate
//  Revision    : 1.0 - initial release
// ============================================================================
module bldc_deadtime_leg
  import bldc_pkg::*;
#(
  parameter int DEAD_CYCLES = 50,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] drive,
  output logic       gh,
  output logic       gl
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             gh_q,    gh_d;
  logic             gl_q,    gl_d;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gh_q    <= 1'b0;
      gl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gh_q    <= gh_d;
      gl_q    <= gl_d;
    end
  end

  // Next state. Leaving HIGH/LOW always passes through DEAD; the request
  // present on the cycle the counter reaches 1 decides where DEAD exits to.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (drive == DRV_HIGH)     state_d = ST_HIGH;
        else if (drive == DRV_LOW) state_d = ST_LOW;
      end
      ST_HIGH: begin
        if (drive != DRV_HIGH) begin
          state_d = ST_DEAD;
          cnt_d   = CNT_W'(DEAD_CYCLES);
        end
      end
      ST_LOW: begin
        if (drive != DRV_LOW) begin
          state_d = ST_DEAD;
          cnt_d   = CNT_W'(DEAD_CYCLES);
        end
      end
      ST_DEAD: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          if (drive == DRV_HIGH)     state_d = ST_HIGH;
          else if (drive == DRV_LOW) state_d = ST_LOW;
          else                       state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Gates are decoded from the next state and registered, so they switch on
  // the same edge as the state without a decode glitch at the pins.
  always_comb begin
    gh_d = (state_d == ST_HIGH);
    gl_d = (state_d == ST_LOW);
  end

  assign gh = gh_q;
  assign gl = gl_q;

endmodule
`default_nettype wire

// File: rtl/bldc_commutator.sv
`default_nettype none
// ============================================================================
//  Module      : bldc_commutator
//  Description : Six-step commutation and gate-drive stage with per-leg
//                dead time.
//  Ports       : clk  - system clock
//                rst  - asynchronous active-low reset
//                bus  - slave side of bldc_commutator_if
//                       in : en, pwm_in, dir, phase_state[2:0]
//                       out: gate_h[2:0], gate_l[2:0] ({C,B,A}), fault,
//                            commutate
//  Revision    : 1.0 - initial release
// ============================================================================
module bldc_commutator
  import bldc_pkg::*;
#(
  parameter int DEAD_CYCLES = 50,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  bldc_commutator_if.slave   bus
);

  logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
  logic [2:0]                  prev_hs_q, prev_hs_d;
  logic                        fault_q, fault_d;
  logic                        commutate_q, commutate_d;

  logic [2:0]      hs;
  logic            hs_bad;
  logic            force_off;
  logic [5:0]      roles;
  logic [2:0][1:0] drive;
  logic [2:0]      gate_h;
  logic [2:0]      gate_l;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q      <= '0;
      prev_hs_q   <= 3'b000;
      fault_q     <= 1'b0;
      commutate_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      prev_hs_q   <= prev_hs_d;
      fault_q     <= fault_d;
      commutate_q <= commutate_d;
    end
  end

  always_comb begin
    // Stage 0 captures the raw asynchronous hall bits
    sync_d    = {sync_q[SYNC_STAGES-2:0], bus.phase_state};
    hs        = sync_q[SYNC_STAGES-1];
    hs_bad    = hall_invalid(hs);
    roles     = comm_table(hs, bus.dir);
    force_off = !bus.en || fault_q || hs_bad;

    for (int i = 0; i < 3; i++) begin
      if (force_off)
        drive[i] = DRV_OFF;
      else if (roles[2*i +: 2] == DRV_HIGH)
        // PWM leg runs complementary: low side fills the PWM off-time
        drive[i] = bus.pwm_in ? DRV_HIGH : DRV_LOW;
      else
        drive[i] = roles[2*i +: 2];
    end

    // Sticky until the motor is disabled
    fault_d     = bus.en && (fault_q || hs_bad);
    commutate_d = bus.en && !hs_bad && !hall_invalid(prev_hs_q) && (hs != prev_hs_q);
    prev_hs_d   = hs;
  end

  for (genvar g = 0; g < 3; g++) begin : g_leg
    bldc_deadtime_leg #(
      .DEAD_CYCLES (DEAD_CYCLES),
      .CNT_W       (CNT_W)
    ) u_leg (
      .clk   (clk),
      .rst   (rst),
      .drive (drive[g]),
      .gh    (gate_h[g]),
      .gl    (gate_l[g])
    );
  end

  assign bus.gate_h    = gate_h;
  assign bus.gate_l    = gate_l;
  assign bus.fault     = fault_q;
  assign bus.commutate = commutate_q;

endmodule
`default_nettype wire

// File: tb/tb_bldc_commutator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bldc_commutator
//  Description : Scoreboard bench for bldc_commutator. A reference model
//                predicts outputs at each clock edge and queues them; a
//                monitor pops and compares on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bldc_commutator;

  localparam int DEAD = 4;
  localparam int SYNC = 2;

  typedef struct packed {
    logic [2:0] gh;
    logic [2:0] gl;
    logic       fault;
    logic       comm;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  int    checks = 0;
  int    errors = 0;
  string phase  = "reset";

  bldc_commutator_if bus ();

  bldc_commutator #(
    .DEAD_CYCLES (DEAD),
    .CNT_W       (8),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Hall row -> index of the high/low leg (0=A,1=B,2=C), -1 for illegal codes
  int         hi_tab [8] = '{-1, 2, 1, 2, 0, 0, 1, -1};
  int         lo_tab [8] = '{-1, 1, 0, 0, 2, 1, 2, -1};
  logic [2:0] ph_hist[$];   // raw hall samples still in flight to hs
  logic [2:0] hs_last;
  bit         m_fault;
  int         leg_on  [3];  // 0 off, 1 high conducting, 2 low conducting
  longint     off_time[3];  // edge index at which the leg last turned off
  longint     now;
  exp_t       exp_q[$];

  function automatic void model_reset();
    ph_hist.delete();
    for (int i = 0; i < SYNC; i++) ph_hist.push_back(3'b000);
    hs_last = 3'b000;
    m_fault = 1'b0;
    now     = 0;
    for (int i = 0; i < 3; i++) begin
      leg_on[i]   = 0;
      off_time[i] = -1000;  // no dead time owed
    end
  endfunction

  function automatic exp_t model_step(input logic en, input logic pwm,
                                      input logic dir, input logic [2:0] ph);
    exp_t       e;
    int         des[3];
    int         h, l;
    logic [2:0] hs;
    bit         valid;
    hs    = ph_hist[0];
    valid = (hi_tab[hs] >= 0);
    for (int i = 0; i < 3; i++) des[i] = 0;
    if (en && !m_fault && valid) begin
      h = dir ? lo_tab[hs] : hi_tab[hs];
      l = dir ? hi_tab[hs] : lo_tab[hs];
      des[h] = pwm ? 1 : 2;
      des[l] = 2;
    end
    for (int i = 0; i < 3; i++) begin
      if (leg_on[i] != 0) begin
        if (des[i] != leg_on[i]) begin
          leg_on[i]   = 0;
          off_time[i] = now;
        end
      end else if (now - off_time[i] >= DEAD) begin
        leg_on[i] = des[i];
      end
    end
    e.comm  = en && valid && (hi_tab[hs_last] >= 0) && (hs != hs_last);
    m_fault = en && (m_fault || !valid);
    e.fault = m_fault;
    hs_last = hs;
    void'(ph_hist.pop_front());
    ph_hist.push_back(ph);
    now++;
    for (int i = 0; i < 3; i++) begin
      e.gh[i] = (leg_on[i] == 1);
      e.gl[i] = (leg_on[i] == 2);
    end
    return e;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        model_reset();
        exp_q.delete();
        exp_q.push_back(exp_t'(0));
      end else begin
        exp_q.push_back(model_step(bus.en, bus.pwm_in, bus.dir, bus.phase_state));
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    exp_t got;
    forever begin
      @(negedge clk);
      got = {bus.gate_h, bus.gate_l, bus.fault, bus.commutate};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s scoreboard_empty t=%0t got %b", phase, $time, got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL %s outputs t=%0t gate_h got %b exp %b gate_l got %b exp %b fault got %b exp %b commutate got %b exp %b",
                   phase, $time, got.gh, e.gh, got.gl, e.gl, got.fault, e.fault, got.comm, e.comm);
        end
      end
      checks++;
      if ((bus.gate_h & bus.gate_l) !== 3'b000) begin
        errors++;
        $display("FAIL %s shoot_through t=%0t gate_h %b gate_l %b required overlap 000",
                 phase, $time, bus.gate_h, bus.gate_l);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  logic [2:0] codes [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

  initial begin
    int hold;
    bus.en = 1'b0; bus.pwm_in = 1'b0; bus.dir = 1'b0; bus.phase_state = 3'b000;
    wait_cyc(3);

    phase = "fwd_101";
    bus.en = 1'b1; bus.pwm_in = 1'b1; bus.phase_state = 3'b101;
    rst = 1'b1;
    wait_cyc(10);

    phase = "pwm_toggle";
    bus.pwm_in = 1'b0; wait_cyc(10);
    bus.pwm_in = 1'b1; wait_cyc(10);

    phase = "commutate_steps";
    bus.phase_state = 3'b100; wait_cyc(10);
    bus.phase_state = 3'b110; wait_cyc(10);

    phase = "fault";
    bus.phase_state = 3'b111; wait_cyc(8);
    bus.phase_state = 3'b101; wait_cyc(8);
    bus.en = 1'b0; wait_cyc(3);
    bus.en = 1'b1; wait_cyc(10);
    bus.phase_state = 3'b000; wait_cyc(6);
    bus.phase_state = 3'b011; bus.en = 1'b0; wait_cyc(3);
    bus.en = 1'b1; wait_cyc(10);

    phase = "reverse";
    bus.dir = 1'b1; bus.phase_state = 3'b101; wait_cyc(12);
    bus.dir = 1'b0; wait_cyc(10);

    phase = "pwm50_disturb";
    for (int p = 0; p < 8; p++) begin
      bus.pwm_in = ~bus.pwm_in;
      if (p == 2) begin
        wait_cyc(2); rst = 1'b0; wait_cyc(3); rst = 1'b1; wait_cyc(5);
      end else if (p == 5) begin
        wait_cyc(2); bus.en = 1'b0; wait_cyc(3); bus.en = 1'b1; wait_cyc(5);
      end else begin
        wait_cyc(10);
      end
    end

    phase = "random";
    hold = 0;
    for (int c = 0; c < 1500; c++) begin
      if (hold == 0) begin
        hold = int'($urandom_range(3, 25));
        if ($urandom_range(0, 9) == 0)
          bus.phase_state = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'b000;
        else
          bus.phase_state = codes[$urandom_range(0, 5)];
      end
      hold--;
      if ($urandom_range(0, 7) == 0)   bus.pwm_in = ~bus.pwm_in;
      if ($urandom_range(0, 199) == 0) bus.dir    = ~bus.dir;
      bus.en = ($urandom_range(0, 39) != 0);
      if (c == 700) rst = 1'b0;
      if (c == 703) rst = 1'b1;
      wait_cyc(1);
    end

    repeat (2) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bldc_commutator.md
Name: bldc_commutator

Overview:
- Six-step commutation and gate-drive stage that sits directly downstream of pwm_generator and bldc_registers.
- Consumes pwm_out, en and the 3-bit hall phase_state.
- Produces six gate signals (high/low side per phase A/B/C) with per-leg dead-time insertion.
- Active high leg switches complementarily with PWM; active low leg stays on; third leg floats.

Parameters:
- DEAD_CYCLES, 50, clk cycles both gates of a leg are held low between turn-off and opposite turn-on (500 ns at 100 MHz); legal range 1..255.
- CNT_W, 8, dead-time counter width; DEAD_CYCLES must be < 2**CNT_W.
- SYNC_STAGES, 2, flop stages synchronising phase_state; minimum 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset; rst=0 resets all state.
- en  input  1  motor enable from bldc_registers.
- pwm_in  input  1  pwm_out from pwm_generator.
- dir  input  1  0 = forward table, 1 = reverse (high/low roles swapped).
- phase_state  input  3  raw hall bits {H3,H2,H1}, asynchronous to clk.
- gate_h  output  3  high-side gates {C,B,A}, registered.
- gate_l  output  3  low-side gates {C,B,A}, registered.
- fault  output  1  invalid hall code seen; sticky.
- commutate  output  1  one-cycle pulse on each valid synced hall change.

Behaviour:
- Reset: gate_h=0, gate_l=0, fault=0, commutate=0, sync chain=0, all legs IDLE, counters=0.
- Sync: phase_state passes through SYNC_STAGES flops. hs is the last stage.
- Forward table (hs -> high leg, low leg):
  - 101 -> A+ B-
  - 100 -> A+ C-
  - 110 -> B+ C-
  - 010 -> B+ A-
  - 011 -> C+ A-
  - 001 -> C+ B-
- dir=1: same row with + and - swapped.
- Desired drive per leg:
  - Active high leg: HIGH if pwm_in=1, else LOW (complementary).
  - Active low leg: LOW.
  - Other leg: OFF.
- Forced to OFF on all legs when en=0, fault=1, or hs is 000/111.
- fault:
  - Sets on the cycle after hs=000 or 111 while en=1.
  - Clears only when en=0 (or reset).
- commutate:
  - Pulses one cycle when hs differs from the previous hs and both codes are valid.
  - No pulse while en=0.
- Leg FSM, states IDLE, HIGH, LOW, DEAD; outputs gh = (state==HIGH), gl = (state==LOW).
  - IDLE: desired HIGH -> HIGH, desired LOW -> LOW, next edge (1-cycle latency).
  - HIGH/LOW: any change of desired -> DEAD with cnt=DEAD_CYCLES. Turn-off is immediate, on the same edge.
  - DEAD:
    - cnt decrements each cycle.
    - When cnt==1: desired OFF -> IDLE; otherwise go directly to desired.
    - The gap with both gates low is exactly DEAD_CYCLES cycles.
    - Desired changes during DEAD do not restart cnt; the value sampled at cnt==1 wins.
  - Same desired as current state: hold.
- Invariant: gate_h[i] & gate_l[i] never 1, including reset release and en toggling mid-DEAD.
- Latency:
  - pwm_in -> gate turn-off: 1 cycle.
  - phase_state -> gate turn-off: SYNC_STAGES+1 cycles.
- Reset mid-operation: all gates drop asynchronously. After release, legs start IDLE with no dead-time owed (both gates were low through reset).

Decomposition:
- Shared package bldc_pkg:
  - Leg-drive encoding OFF=2'b00, HIGH=2'b01, LOW=2'b10.
  - Leg FSM state encodings.
  - Commutation-table function (hs, dir) -> 3 leg drives.
  - Invalid-hall constants 3'b000 / 3'b111.
- Sub-module bldc_deadtime_leg:
  - Ports clk, rst, drive[1:0] -> gh, gl.
  - Holds leg FSM plus CNT_W counter; instantiated three times.
- Top holds the synchroniser, table lookup, fault and commutate logic.

Test Plan:
- Bench uses DEAD_CYCLES=4, SYNC_STAGES=2 unless stated.
- Reset then en=1, dir=0, phase_state=101, pwm_in=1 held -> gate_h=001, gate_l=010 within 4 cycles of rst release; never h&l on any leg.
- Same setup, pwm_in toggles 1->0 -> gate_h[0] falls 1 cycle later; gate_l[0] rises exactly 4 cycles after that. Symmetric on 0->1. gate_l[1] stays 1 throughout.
- pwm_in=1, step phase_state 101->100->110 -> commutate pulses once per step, 3 cycles after each change.
  - 101->100: B low turns off, C low turns on with no dead wait (C was IDLE).
  - 100->110: A high off, B high on.
- phase_state=111 with en=1 -> fault=1 and all gates 0 within 4 cycles. Return to 101: fault stays 1, gates stay 0. en=0 then en=1 -> fault clears, drive resumes.
- dir=1, phase_state=101, pwm_in=1 -> gate_h=010, gate_l=001.
- pwm_in toggling at 50% with period 20 cycles; assert rst=0 mid-DEAD and en=0 mid-DEAD:
  - gates drop to 0 immediately.
  - No cycle anywhere with gate_h[i]&gate_l[i]=1.
  - After release, first turn-on follows the 1-cycle IDLE latency.
